// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the universal-gate sweep sequencer.
// Bit order of the gate bundle: NOT, AND, OR, NAND, NOR, XOR, XNOR.
package gate_sweep_pkg;

  localparam int NUM_GATES = 7;

  localparam int GATE_NOT  = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [NUM_GATES-1:0] golden(input logic a, input logic b);
    logic [NUM_GATES-1:0] g;
    g            = {NUM_GATES{1'b0}};
    g[GATE_NOT]  = ~a;
    g[GATE_AND]  = a & b;
    g[GATE_OR]   = a | b;
    g[GATE_NAND] = ~(a & b);
    g[GATE_NOR]  = ~(a | b);
    g[GATE_XOR]  = a ^ b;
    g[GATE_XNOR] = ~(a ^ b);
    return g;
  endfunction

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 7; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl.sv
// Hardware sweep of all four (A,B) combinations through a 2-input gate block,
// checking the seven outputs against golden values after a programmable settle.
module gate_sweep_ctrl #(
  parameter int SETTLE    = 1,
  parameter int NUM_GATES = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_GATES-1:0] y_in,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] err_mask,
  output logic [4:0]           err_count
);

  import gate_sweep_pkg::*;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [1:0]             vec_r;
  logic [3:0]             cnt_r;
  logic                   a_r;
  logic                   b_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   pass_r;
  logic [NUM_GATES-1:0]   err_mask_r;
  logic [4:0]             err_count_r;
  logic [NUM_GATES-1:0]   diff_s;
  logic [4:0]             sum_s;

  // Next-state decode and per-vector mismatch evaluation.
  always_comb begin
    state_nx_s = state_r;
    diff_s     = y_in ^ golden(a_r, b_r);
    sum_s      = err_count_r + {2'b00, popcount7(diff_s)};
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = WAIT;
        else       state_nx_s = IDLE;
      end
      WAIT: begin
        if (cnt_r == 4'd0) state_nx_s = CHECK;
        else               state_nx_s = WAIT;
      end
      CHECK: begin
        if (vec_r == 2'd3) state_nx_s = DONE;
        else               state_nx_s = WAIT;
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, stimulus, settle counter and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      vec_r       <= 2'd0;
      cnt_r       <= 4'd0;
      a_r         <= 1'b0;
      b_r         <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_mask_r  <= {NUM_GATES{1'b0}};
      err_count_r <= 5'd0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == WAIT) || (state_nx_s == CHECK);
      done_r  <= (state_nx_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            vec_r       <= 2'd0;
            {a_r, b_r}  <= 2'b00;
            cnt_r       <= SETTLE_LOAD;
            pass_r      <= 1'b0;
            err_mask_r  <= {NUM_GATES{1'b0}};
            err_count_r <= 5'd0;
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) cnt_r <= cnt_r - 4'd1;
        end
        CHECK: begin
          err_mask_r  <= err_mask_r | diff_s;
          err_count_r <= sum_s;
          if (vec_r != 2'd3) begin
            vec_r      <= vec_r + 2'd1;
            {a_r, b_r} <= vec_r + 2'd1;
            cnt_r      <= SETTLE_LOAD;
          end else begin
            // Decide pass on the final count so it is valid in the done cycle.
            pass_r <= (sum_s == 5'd0);
          end
        end
        DONE: begin
          vec_r <= vec_r;
        end
        default: begin
          vec_r <= 2'd0;
        end
      endcase
    end
  end

  assign a         = a_r;
  assign b         = b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_mask  = err_mask_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: table of gate fault modes plus
// hand-written sequences for back-to-back starts, mid-sweep reset and settle glitches.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start3, glitch;
  int         mode;
  logic       a, b, busy, done, pass;
  logic [6:0] err_mask, y_in;
  logic [4:0] err_count;
  logic       a3, b3, busy3, done3, pass3;
  logic [6:0] err_mask3, y3;
  logic [4:0] err_count3;

  int errors = 0;
  int checks = 0;

  function automatic logic [6:0] gm(input logic ga, input logic gb);
    return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb, ~ga};
  endfunction

  function automatic logic [6:0] faulty(input int m, input logic [6:0] g);
    logic [6:0] r;
    r = g;
    case (m)
      1:       r[1] = 1'b0;
      2:       r[5] = g[6];
      3:       r = ~g;
      4:       r[0] = 1'b1;
      default: r = g;
    endcase
    return r;
  endfunction

  assign y_in = faulty(mode, gm(a, b));
  assign y3   = glitch ? ~gm(a3, b3) : gm(a3, b3);

  gate_sweep_ctrl #(.SETTLE(1), .NUM_GATES(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .err_count(err_count)
  );

  gate_sweep_ctrl #(.SETTLE(3), .NUM_GATES(7)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .y_in(y3),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_mask(err_mask3), .err_count(err_count3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One SETTLE=1 sweep from IDLE, checking stimulus, busy and done every cycle.
  task automatic run_sweep(input int m, input logic ep, input logic [6:0] em, input logic [4:0] ec);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      chk("busy", busy, (i < 8) ? 1 : 0);
      chk("done", done, (i == 8) ? 1 : 0);
      chk("ab", {a, b}, (i < 8) ? i / 2 : 3);
      if (i == 8) begin
        chk("pass", pass, ep);
        chk("err_mask", err_mask, em);
        chk("err_count", err_count, ec);
      end
    end
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("pass_hold", pass, ep);
    chk("count_hold", err_count, ec);
  endtask

  typedef struct {
    int         m;
    logic       ep;
    logic [6:0] em;
    logic [4:0] ec;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int   gap, gaps, dones;
    logic prev_busy, seen_busy;

    tbl[0] = '{0, 1'b1, 7'b0000000, 5'd0};
    tbl[1] = '{1, 1'b0, 7'b0000010, 5'd1};
    tbl[2] = '{2, 1'b0, 7'b0100000, 5'd4};
    tbl[3] = '{3, 1'b0, 7'b1111111, 5'd28};
    tbl[4] = '{4, 1'b0, 7'b0000001, 5'd2};

    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    glitch = 1'b0;
    mode   = 0;
    #12;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mask", err_mask, 0);
    chk("rst_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      run_sweep(tbl[t].m, tbl[t].ep, tbl[t].em, tbl[t].ec);
    end

    // start held high: first sweep faulty, later ones clean; gaps must be 2 cycles
    mode = 3;
    @(negedge clk);
    start     = 1'b1;
    prev_busy = 1'b0;
    seen_busy = 1'b0;
    gap       = 0;
    gaps      = 0;
    dones     = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (busy && !prev_busy) begin
        chk("clear_on_accept", err_count, 0);
        if (seen_busy) begin
          chk("gap", gap, 2);
          gaps++;
        end
        seen_busy = 1'b1;
      end
      if (busy) gap = 0;
      else      gap++;
      if (done) begin
        if (dones == 0) begin
          chk("held_first_count", err_count, 28);
        end else begin
          chk("held_count", err_count, 0);
          chk("held_pass", pass, 1);
        end
        dones++;
        mode = 0;
      end
      prev_busy = busy;
    end
    chk("held_gaps", gaps, 2);
    chk("held_dones", dones, 3);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);

    // reset during vector 2 after two faulty vectors accumulated
    mode = 3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_ab", {a, b}, 2);
    chk("mid_count", err_count, 14);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a", a, 0);
    chk("arst_b", b, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_mask", err_mask, 0);
    chk("arst_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 1'b1, 7'b0000000, 5'd0);

    // SETTLE=3: outputs wrong during WAIT only, correct in CHECK cycles
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      glitch = (c < 16) && ((c % 4) != 3);
      if (c == 15) chk("s3_busy", busy3, 1);
      if (c >= 15) chk("s3_done", done3, (c == 16) ? 1 : 0);
      if (c == 16) begin
        chk("s3_pass", pass3, 1);
        chk("s3_count", err_count3, 0);
        chk("s3_mask", err_mask3, 0);
      end
    end
    glitch = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
